// File: rtl/cpu_seq_pkg.sv
// Shared encodings for the cpu_seq instruction sequencer: FSM states, decoder
// instruction-format codes and the ECALL instruction word.
package cpu_seq_pkg;

  typedef enum logic [2:0] {
    StIdle   = 3'd0,
    StFetch  = 3'd1,
    StDecode = 3'd2,
    StExec   = 3'd3,
    StMem    = 3'd4,
    StWb     = 3'd5,
    StHalt   = 3'd6
  } state_e;

  typedef enum logic [2:0] {
    FmtR = 3'd0,
    FmtI = 3'd1,
    FmtS = 3'd2,
    FmtB = 3'd3,
    FmtU = 3'd4,
    FmtJ = 3'd5
  } fmt_e;

  localparam logic [31:0] Ecall = 32'h0000_0073;

  // Formats that produce a destination-register result.
  function automatic logic fmt_writes_rf(input logic [2:0] fmt);
    return (fmt == FmtR) || (fmt == FmtI) || (fmt == FmtU) || (fmt == FmtJ);
  endfunction

endpackage

// File: rtl/seq_timeout_ctr.sv
// Handshake watchdog: counts cycles a request has been held without
// completion and flags expiry on the TIMEOUT-th such cycle.
module seq_timeout_ctr
  import cpu_seq_pkg::*;
#(
  parameter int unsigned TIMEOUT = 255
) (
  input  logic clk,
  input  logic rst,
  input  logic req,
  output logic expired
);

  logic [7:0] cnt_q;

  // Requests are always separated by idle cycles, so clearing while low
  // restarts the count on every request rise.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      cnt_q <= '0;
    end else if (!req) begin
      cnt_q <= '0;
    end else if (!expired) begin
      cnt_q <= cnt_q + 8'd1;
    end
  end

  assign expired = req && (cnt_q == 8'(TIMEOUT - 1));

endmodule

// File: rtl/cpu_seq.sv
// Multi-cycle instruction sequencer (FETCH/DECODE/EXEC/MEM/WB) with a
// handshake watchdog. Define CPU_SEQ_PERF_EN to build the retired counter.
module cpu_seq
  import cpu_seq_pkg::*;
#(
  parameter logic [31:0] RESET_PC = 32'h0000_0000,
  parameter int unsigned TIMEOUT  = 255
) (
  input  logic        CLK,
  input  logic        RST,
  input  logic        start,
  output logic        imem_req,
  output logic [31:0] imem_addr,
  input  logic        imem_ack,
  input  logic [31:0] imem_rdata,
  output logic [31:0] instr,
  output logic [31:0] pc,
  input  logic [2:0]  instr_format,
  input  logic        is_mem,
  input  logic        br_taken,
  input  logic [31:0] br_target,
  output logic        dmem_req,
  input  logic        dmem_ack,
  output logic        rf_we,
  output logic        busy,
  output logic        halt,
  output logic        err,
  output logic [31:0] retired
);

  state_e      state_q;
  logic [31:0] pc_q, instr_q, tgt_q;
  logic        br_q, wr_q, err_q;
  logic        expired;

  seq_timeout_ctr #(
    .TIMEOUT (TIMEOUT)
  ) u_timeout (
    .clk     (CLK),
    .rst     (RST),
    .req     (imem_req | dmem_req),
    .expired (expired)
  );

  always_ff @(posedge CLK or posedge RST) begin
    if (RST) begin
      state_q <= StIdle;
      pc_q    <= RESET_PC;
      instr_q <= '0;
      tgt_q   <= '0;
      br_q    <= 1'b0;
      wr_q    <= 1'b0;
      err_q   <= 1'b0;
    end else begin
      case (state_q)
        StIdle: if (start) state_q <= StFetch;
        StFetch: begin
          if (imem_ack) begin
            instr_q <= imem_rdata;
            state_q <= StDecode;
          end else if (expired) begin
            err_q   <= 1'b1;
            state_q <= StHalt;
          end
        end
        StDecode: state_q <= (instr_q == Ecall) ? StHalt : StExec;
        StExec: begin
          // Decoder/branch inputs are only guaranteed valid here, so capture them.
          br_q    <= br_taken;
          tgt_q   <= br_target;
          wr_q    <= fmt_writes_rf(instr_format);
          state_q <= is_mem ? StMem : StWb;
        end
        StMem: begin
          if (dmem_ack) begin
            state_q <= StWb;
          end else if (expired) begin
            err_q   <= 1'b1;
            state_q <= StHalt;
          end
        end
        StWb: begin
          pc_q    <= br_q ? tgt_q : pc_q + 32'd4;
          state_q <= StFetch;
        end
        StHalt:  state_q <= StHalt;
        default: state_q <= StIdle;
      endcase
    end
  end

  assign imem_req  = (state_q == StFetch);
  assign dmem_req  = (state_q == StMem);
  assign rf_we     = (state_q == StWb) && wr_q;
  assign halt      = (state_q == StHalt);
  assign busy      = (state_q != StIdle) && (state_q != StHalt);
  assign err       = err_q;
  assign imem_addr = pc_q;
  assign pc        = pc_q;
  assign instr     = instr_q;

`ifdef CPU_SEQ_PERF_EN
  logic [31:0] retired_q;

  always_ff @(posedge CLK or posedge RST) begin
    if (RST) begin
      retired_q <= '0;
    end else if (state_q == StWb) begin
      retired_q <= retired_q + 32'd1;
    end
  end

  assign retired = retired_q;
`else
  assign retired = '0;
`endif

endmodule
